dcmac_tx_pack: RTL
==================

# dcmac_tx_pack

Transmit-side segment packer for the DCMAC segmented AXI-Stream TX interface. It is the mirror of the RX deskew path. Its input is a packet-aligned stream in which every packet starts on segment 0, and its output is a dense segmented stream in which a new packet starts in the segment immediately after the previous packet's end. Holding up to SEG_COUNT-1 leftover segments between beats removes the idle-segment bubbles that packet alignment would otherwise leave. It sits between the user TX datapath and the DCMAC TX port.

## Interface
- SEG_COUNT, 2, segments per logical port; legal values 2 or 4.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- in<n>_tdata (n=0..3)  in  128  segment payload.
- in<n>_tid  in  4  segment port ID; passed through unchanged.
- in<n>_tuser  in  3  bit0 ERR, bit1 SOP, bit2 ENA (segment carries data).
- in<n>_tlast  in  1  segment holds the packet's last byte.
- in_tvalid  in  1  input beat valid; one handshake covers all segments.
- in_tready  out  1  input beat accepted when in_tvalid & in_tready.
- out<n>_tdata / out<n>_tid / out<n>_tuser / out<n>_tlast  out  128/4/3/1  registered output segments; same field meanings as the inputs.
- out_tvalid  out  1  output beat valid.
- out_tready  in  1  DCMAC TX ready.
- dbg_hold_count  out  2  number of segments in the holding register.
- Segments 2..3 are ignored on input and driven 0 on output when SEG_COUNT=2.

## Operation
- Active input segment: tuser ENA=1. On a valid beat, the active segments are contiguous starting from segment 0; n_in = number of active segments (1..SEG_COUNT).
- Holding register H: ordered list of h segments, 0 ≤ h ≤ SEG_COUNT-1. Each entry stores tdata, tid, tuser and tlast.
- Output register O: SEG_COUNT segments plus out_tvalid. O is free when out_tvalid=0 or out_tready=1.
- in_tready = O free. This is combinational; there is no dependence on in_tvalid.
- Accepted beat: form C = H followed by the active input segments in order; c = h + n_in, max 2·SEG_COUNT-1.
  - If c ≥ SEG_COUNT: load C[0..SEG_COUNT-1] into O and set out_tvalid=1. Move C[SEG_COUNT..c-1] into H[0..], so h ← c-SEG_COUNT.
  - If c < SEG_COUNT: H ← C, h ← c; O gets no new beat, so out_tvalid ← 0 if it was consumed.
- Flush: if O is free, no input beat is accepted (in_tvalid=0) and h>0, then:
  - load H into O[0..h-1];
  - fill O[h..SEG_COUNT-1] with zeros (ENA=0, tlast=0);
  - set out_tvalid=1 and h ← 0.
  - Idle segments inside a packet are legal on the DCMAC TX output.
- Idle: O free, no accepted beat, h=0 → out_tvalid ← 0.
- Output register hold: while out_tvalid=1 and out_tready=0, O and H hold and in_tready=0.
- Field handling: SOP, ERR, tid and tlast are copied unchanged with their segment. The block never creates or removes SOP/EOP flags.
- Output segments with ENA=0 have tdata, tid, tuser and tlast all zero.
- Illegal input (ENA gaps, or inactive segment 0 on a valid beat): behaviour is undefined; no checking is required.

## Timing
- Reset values: out_tvalid=0, all out<n>_* fields 0, h=0, dbg_hold_count=0. in_tready=1 after reset (O is free).
- Reset asserted mid-packet: everything clears immediately and held segments are discarded. The first beat after reset release is treated as fresh.
- Latency:
  - When c ≥ SEG_COUNT, input segments appear on the output 1 cycle after acceptance.
  - Segments left in H appear on the next output beat: either 1 cycle after the next accepted beat completes a group, or 1 cycle after the first cycle with in_tvalid=0 and O free.
- Throughput: one input beat per cycle while out_tready=1. The output never reorders segments.
- Simultaneous case: O being consumed (out_tready=1) and a new beat accepted in the same cycle is a normal full-rate transfer.
- A flush and an accept never occur in the same cycle; an accept takes precedence.

## Test plan
- SEG_COUNT=4, after reset: check out_tvalid=0, in_tready=1, dbg_hold_count=0.
- SEG_COUNT=4, four back-to-back input beats, each one segment with SOP+tlast and tdata = 1, 2, 3, 4:
  - after beats 1–3: no output; dbg_hold_count = 1, 2, 3;
  - 1 cycle after beat 4: one output beat with out0..3_tdata = 1, 2, 3, 4, all with SOP and tlast.
- SEG_COUNT=4, a 6-segment packet (beat A with 4 segments, then beat B with 2 segments, tlast on B segment 1), then in_tvalid=0:
  - output beat 1 = A;
  - output beat 2 = B segments 0–1 plus 2 ENA=0 zero segments (flush).
- SEG_COUNT=4, h=3 held, then a 4-segment input beat X:
  - output = H0, H1, H2, X0;
  - dbg_hold_count=3 holding X1..X3.
- Hold out_tready=0 for 5 cycles with out_tvalid=1:
  - outputs stay stable and in_tready=0 throughout;
  - on release, the next beat follows with no segment lost or duplicated.
- SEG_COUNT=2, alternating 1-segment and 2-segment packets with random out_tready:
  - the output segment sequence equals the concatenation of active input segments;
  - assert reset mid-stream and check that all outputs read 0 in the same cycle.

Source files
------------

// File: rtl/dcmac_tx_pack.sv
// Segment packer for the DCMAC segmented TX stream: compacts packet-aligned input beats into
// dense output beats, carrying up to SEG_COUNT-1 leftover segments between beats.
module dcmac_tx_pack #(
  parameter int unsigned SEG_COUNT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] in0_tdata,
  input  logic [3:0]   in0_tid,
  input  logic [2:0]   in0_tuser,
  input  logic         in0_tlast,
  input  logic [127:0] in1_tdata,
  input  logic [3:0]   in1_tid,
  input  logic [2:0]   in1_tuser,
  input  logic         in1_tlast,
  input  logic [127:0] in2_tdata,
  input  logic [3:0]   in2_tid,
  input  logic [2:0]   in2_tuser,
  input  logic         in2_tlast,
  input  logic [127:0] in3_tdata,
  input  logic [3:0]   in3_tid,
  input  logic [2:0]   in3_tuser,
  input  logic         in3_tlast,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [127:0] out0_tdata,
  output logic [3:0]   out0_tid,
  output logic [2:0]   out0_tuser,
  output logic         out0_tlast,
  output logic [127:0] out1_tdata,
  output logic [3:0]   out1_tid,
  output logic [2:0]   out1_tuser,
  output logic         out1_tlast,
  output logic [127:0] out2_tdata,
  output logic [3:0]   out2_tid,
  output logic [2:0]   out2_tuser,
  output logic         out2_tlast,
  output logic [127:0] out3_tdata,
  output logic [3:0]   out3_tid,
  output logic [2:0]   out3_tuser,
  output logic         out3_tlast,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic [1:0]   dbg_hold_count
);

  // Segment word layout: {tlast, tuser[2:0], tid[3:0], tdata[127:0]}.
  localparam int unsigned SegW   = 136;
  localparam int unsigned EnaBit = 134;
  localparam int          SegN   = int'(SEG_COUNT);
  localparam logic [2:0]  SegCnt = 3'(SEG_COUNT);

  logic [SegW-1:0] in_seg    [4];
  logic [SegW-1:0] cat_seg   [8];
  logic [SegW-1:0] out_seg_d [4];
  logic [SegW-1:0] out_seg_q [4];
  logic [SegW-1:0] hold_d    [3];
  logic [SegW-1:0] hold_q    [3];
  logic [1:0]      hold_cnt_d, hold_cnt_q;
  logic            out_tvalid_d, out_tvalid_q;
  logic [2:0]      n_in, cat_cnt;
  logic            o_free, accept;

  assign in_seg[0] = {in0_tlast, in0_tuser, in0_tid, in0_tdata};
  assign in_seg[1] = {in1_tlast, in1_tuser, in1_tid, in1_tdata};
  assign in_seg[2] = {in2_tlast, in2_tuser, in2_tid, in2_tdata};
  assign in_seg[3] = {in3_tlast, in3_tuser, in3_tid, in3_tdata};

  assign o_free    = ~out_tvalid_q | out_tready;
  assign in_tready = o_free;
  assign accept    = in_tvalid & o_free;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < SegN && in_seg[i][EnaBit]) n_in = n_in + 3'd1;
    end
  end

  // C = held segments followed by the active input segments; unused slots stay zero.
  always_comb begin
    for (int k = 0; k < 8; k++) cat_seg[k] = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(hold_cnt_q)) cat_seg[k] = hold_q[k];
    end
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n_in)) cat_seg[i + int'(hold_cnt_q)] = in_seg[i];
    end
  end

  assign cat_cnt = {1'b0, hold_cnt_q} + n_in;

  always_comb begin
    out_seg_d    = out_seg_q;
    out_tvalid_d = out_tvalid_q;
    hold_d       = hold_q;
    hold_cnt_d   = hold_cnt_q;
    if (accept) begin
      if (cat_cnt >= SegCnt) begin
        out_tvalid_d = 1'b1;
        for (int i = 0; i < 4; i++) out_seg_d[i] = (i < SegN) ? cat_seg[i] : '0;
        for (int j = 0; j < 3; j++) hold_d[j] = cat_seg[j + SegN];
        hold_cnt_d = 2'(cat_cnt - SegCnt);
      end else begin
        out_tvalid_d = 1'b0;
        for (int i = 0; i < 4; i++) out_seg_d[i] = '0;
        for (int j = 0; j < 3; j++) hold_d[j] = cat_seg[j];
        hold_cnt_d = 2'(cat_cnt);
      end
    end else if (o_free && hold_cnt_q != 2'd0) begin
      // Flush leftovers; trailing segments go out as zeroed idle segments.
      out_tvalid_d = 1'b1;
      for (int i = 0; i < 4; i++) out_seg_d[i] = (i < int'(hold_cnt_q)) ? cat_seg[i] : '0;
      for (int j = 0; j < 3; j++) hold_d[j] = '0;
      hold_cnt_d = 2'd0;
    end else if (o_free) begin
      out_tvalid_d = 1'b0;
      for (int i = 0; i < 4; i++) out_seg_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) out_seg_q[i] <= '0;
      for (int j = 0; j < 3; j++) hold_q[j] <= '0;
      hold_cnt_q   <= '0;
      out_tvalid_q <= 1'b0;
    end else begin
      out_seg_q    <= out_seg_d;
      hold_q       <= hold_d;
      hold_cnt_q   <= hold_cnt_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

  assign out_tvalid     = out_tvalid_q;
  assign dbg_hold_count = hold_cnt_q;

  assign out0_tdata = out_seg_q[0][127:0];
  assign out0_tid   = out_seg_q[0][131:128];
  assign out0_tuser = out_seg_q[0][134:132];
  assign out0_tlast = out_seg_q[0][135];
  assign out1_tdata = out_seg_q[1][127:0];
  assign out1_tid   = out_seg_q[1][131:128];
  assign out1_tuser = out_seg_q[1][134:132];
  assign out1_tlast = out_seg_q[1][135];
  assign out2_tdata = out_seg_q[2][127:0];
  assign out2_tid   = out_seg_q[2][131:128];
  assign out2_tuser = out_seg_q[2][134:132];
  assign out2_tlast = out_seg_q[2][135];
  assign out3_tdata = out_seg_q[3][127:0];
  assign out3_tid   = out_seg_q[3][131:128];
  assign out3_tuser = out_seg_q[3][134:132];
  assign out3_tlast = out_seg_q[3][135];

endmodule
